vga_sync_decoder: RTL
=====================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_TOTAL, 1904, clocks per line
- H_ACT_START, 384, first active h position
- H_ACT_END, 1823, last active h position
- V_TOTAL, 932, lines per frame
- V_ACT_START, 31, first active line
- V_ACT_END, 930, last active line
REQ-002 Ports (name, direction, width, meaning), one per line:
- clkgen, in, 1, pixel clock
- rst, in, 1, asynchronous active-high reset
- hsync, in, 1, line sync, active-low
- vsync, in, 1, frame sync, active-high
- pix_r / pix_g / pix_b, in, 4 each, incoming pixel colour
- out_r / out_g / out_b, out, 4 each, captured pixel colour
- out_x, out, 11, active-area column
- out_y, out, 10, active-area row
- pix_valid, out, 1, out_* hold an active pixel
- locked, out, 1, timing lock achieved
- sync_err, out, 1, one-cycle pulse on timing violation
- err_count, out, 8, saturating violation count

Function
REQ-003 Stage 1 SHALL register hsync, vsync and pix_* every clkgen edge; all decoding SHALL use only these stage-1 values.
- hs_fall: stage-1 hsync 1 -> 0
- vs_rise: stage-1 vsync 0 -> 1
REQ-004 h_cnt (11b) SHALL be 0 in the hs_fall cycle, else increment, saturating at 2047.
REQ-005 v_cnt (10b) SHALL be 0 when vs_rise and hs_fall coincide; on hs_fall alone it SHALL increment, saturating at 1023.
REQ-006 Each violation SHALL pulse sync_err for exactly one cycle:
- hs_fall while previous h_cnt != H_TOTAL-1
- vs_rise without a coincident hs_fall
- vs_rise while previous v_cnt != V_TOTAL-1
- h_cnt reaching 2047 (hsync lost)
REQ-007 Every sync_err pulse SHALL increment err_count, saturating at 255. Multiple violations in one cycle SHALL count as one.
REQ-008 FSM SHALL have three states: SEARCH, MEASURE, LOCKED.
- SEARCH -> MEASURE on first vs_rise with hs_fall.
- MEASURE -> LOCKED on the next vs_rise if no violation occurred since entry.
- MEASURE with a violation SHALL restart MEASURE at the next valid vs_rise.
- LOCKED -> SEARCH on any violation.
REQ-009 In SEARCH, violations SHALL NOT pulse sync_err or increment err_count.
REQ-010 locked SHALL be 1 only in LOCKED, and SHALL drop in the cycle after the violation.
REQ-011 Stage 2 (registered output) SHALL be written every cycle:
- pix_valid = locked state AND H_ACT_START <= h_cnt <= H_ACT_END AND V_ACT_START <= v_cnt <= V_ACT_END
- out_x = h_cnt - H_ACT_START, out_y = v_cnt - V_ACT_START
- out_r/g/b = stage-1 colour
REQ-012 out_x, out_y and out_r/g/b SHALL hold their last values while pix_valid = 0.
REQ-013 Latency from pin to stage-2 output SHALL be exactly 2 clkgen cycles.

Reset
REQ-014 rst SHALL act asynchronously. Every register SHALL be 0, except stage-1 hsync, which SHALL reset to 1.
- Reset values: state SEARCH; all outputs 0; h_cnt 0; v_cnt 0.
REQ-015 Deasserting rst mid-frame SHALL resume in SEARCH, with no sync_err until MEASURE is entered.

Structure
REQ-016 A shared package vga_timing_pkg SHALL hold the timing constants (shared with the timing generator) and the FSM state encoding.
REQ-017 Edge detect and counters SHALL form one sub-module, vga_sync_counter, outputting h_cnt, v_cnt, hs_fall and vs_rise.
- FSM, error logic and output stage SHALL stay in the top module.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Nominal generator timing (1904x932, hsync low 152 clocks, vsync high 3 lines): locked rises at the start of the 2nd full frame; 1440x900 pix_valid pixels per frame; first valid pixel out_x=0, out_y=0; last out_x=1439, out_y=899.
- Colour pattern r=h[3:0]: out_r follows the pin values with 2-cycle latency.
- One line of 1903 clocks while locked: one sync_err pulse; err_count=1; locked drops; relock after 2 clean frames.
- hsync held high 3000 cycles while locked: sync_err at h_cnt=2047; state SEARCH; err_count increments once.
- Garbage sync before first lock: err_count stays 0.
- rst asserted mid-frame: all outputs 0 asynchronously. After release, relock occurs at the same frame offset as from power-up.
- 300 forced violations: err_count saturates at 255.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Timing constants shared with the VGA timing generator, plus the
// sync-decoder FSM encoding and counter saturation limits.
package vga_timing_pkg;

  localparam int DEF_H_TOTAL     = 1904;
  localparam int DEF_H_ACT_START = 384;
  localparam int DEF_H_ACT_END   = 1823;
  localparam int DEF_V_TOTAL     = 932;
  localparam int DEF_V_ACT_START = 31;
  localparam int DEF_V_ACT_END   = 930;

  localparam logic [10:0] H_CNT_MAX = 11'd2047;
  localparam logic [9:0]  V_CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_t;

endpackage

// File: rtl/vga_sync_counter.sv
// Sync edge detection and saturating h/v position counters, driven by the
// already-registered stage-1 sync levels.
module vga_sync_counter
  import vga_timing_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_s1,
  input  logic        vsync_s1,
  output logic        hs_fall,
  output logic        vs_rise,
  output logic [10:0] h_cnt,
  output logic [9:0]  v_cnt,
  output logic [10:0] h_prev,
  output logic [9:0]  v_prev
);

  logic hsync_d;
  logic vsync_d;

  // h_prev/v_prev carry last cycle's position so the count itself can be
  // decoded in the same cycle as the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_d <= 1'b0;
      vsync_d <= 1'b0;
      h_prev  <= 11'd0;
      v_prev  <= 10'd0;
    end else begin
      hsync_d <= hsync_s1;
      vsync_d <= vsync_s1;
      h_prev  <= h_cnt;
      v_prev  <= v_cnt;
    end
  end

  always_comb begin
    hs_fall = hsync_d & ~hsync_s1;
    vs_rise = vsync_s1 & ~vsync_d;

    if (hs_fall) begin
      h_cnt = 11'd0;
    end else if (h_prev == H_CNT_MAX) begin
      h_cnt = H_CNT_MAX;
    end else begin
      h_cnt = h_prev + 11'd1;
    end

    if (hs_fall && vs_rise) begin
      v_cnt = 10'd0;
    end else if (hs_fall) begin
      v_cnt = (v_prev == V_CNT_MAX) ? V_CNT_MAX : v_prev + 10'd1;
    end else begin
      v_cnt = v_prev;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: locks onto incoming hsync/vsync timing, flags timing
// violations and emits active-area pixels with their coordinates.
module vga_sync_decoder #(
  parameter int H_TOTAL     = vga_timing_pkg::DEF_H_TOTAL,
  parameter int H_ACT_START = vga_timing_pkg::DEF_H_ACT_START,
  parameter int H_ACT_END   = vga_timing_pkg::DEF_H_ACT_END,
  parameter int V_TOTAL     = vga_timing_pkg::DEF_V_TOTAL,
  parameter int V_ACT_START = vga_timing_pkg::DEF_V_ACT_START,
  parameter int V_ACT_END   = vga_timing_pkg::DEF_V_ACT_END
) (
  input  logic        clkgen,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  pix_r,
  input  logic [3:0]  pix_g,
  input  logic [3:0]  pix_b,
  output logic [3:0]  out_r,
  output logic [3:0]  out_g,
  output logic [3:0]  out_b,
  output logic [10:0] out_x,
  output logic [9:0]  out_y,
  output logic        pix_valid,
  output logic        locked,
  output logic        sync_err,
  output logic [7:0]  err_count
);
  import vga_timing_pkg::*;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_LO   = 11'(H_ACT_START);
  localparam logic [10:0] H_HI   = 11'(H_ACT_END);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_LO   = 10'(V_ACT_START);
  localparam logic [9:0]  V_HI   = 10'(V_ACT_END);

  logic        hsync_s1;
  logic        vsync_s1;
  logic [3:0]  r_s1;
  logic [3:0]  g_s1;
  logic [3:0]  b_s1;

  logic        hs_fall;
  logic        vs_rise;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [10:0] h_prev;
  logic [9:0]  v_prev;

  sync_state_t state;
  sync_state_t state_next;
  logic        meas_bad;
  logic        meas_bad_next;
  logic        timing_bad;
  logic        frame_start;
  logic        viol;
  logic        active;

  // hsync idles high, so its stage-1 copy resets high to avoid a false edge.
  always_ff @(posedge clkgen or posedge rst) begin
    if (rst) begin
      hsync_s1 <= 1'b1;
      vsync_s1 <= 1'b0;
      r_s1     <= 4'd0;
      g_s1     <= 4'd0;
      b_s1     <= 4'd0;
    end else begin
      hsync_s1 <= hsync;
      vsync_s1 <= vsync;
      r_s1     <= pix_r;
      g_s1     <= pix_g;
      b_s1     <= pix_b;
    end
  end

  vga_sync_counter u_counter (
    .clk      (clkgen),
    .rst      (rst),
    .hsync_s1 (hsync_s1),
    .vsync_s1 (vsync_s1),
    .hs_fall  (hs_fall),
    .vs_rise  (vs_rise),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .h_prev   (h_prev),
    .v_prev   (v_prev)
  );

  always_comb begin
    timing_bad = 1'b0;
    if (hs_fall && (h_prev != H_LAST)) begin
      timing_bad = 1'b1;
    end
    if (vs_rise && !hs_fall) begin
      timing_bad = 1'b1;
    end
    if (vs_rise && (v_prev != V_LAST)) begin
      timing_bad = 1'b1;
    end
    // Flag the lost-hsync condition once, on the cycle the counter pins.
    if ((h_cnt == H_CNT_MAX) && (h_prev != H_CNT_MAX)) begin
      timing_bad = 1'b1;
    end
  end

  assign frame_start = vs_rise & hs_fall;
  assign viol        = timing_bad & (state != SEARCH);
  assign active      = (state == LOCKED) &&
                       (h_cnt >= H_LO) && (h_cnt <= H_HI) &&
                       (v_cnt >= V_LO) && (v_cnt <= V_HI);

  always_comb begin
    state_next    = state;
    meas_bad_next = meas_bad;
    case (state)
      SEARCH: begin
        if (frame_start) begin
          state_next    = MEASURE;
          meas_bad_next = 1'b0;
        end else begin
          state_next    = SEARCH;
        end
      end
      MEASURE: begin
        // A frame boundary either promotes a clean frame or starts a new
        // measurement window.
        if (frame_start) begin
          state_next    = (meas_bad || timing_bad) ? MEASURE : LOCKED;
          meas_bad_next = 1'b0;
        end else if (timing_bad) begin
          meas_bad_next = 1'b1;
        end else begin
          meas_bad_next = meas_bad;
        end
      end
      LOCKED: begin
        if (timing_bad) begin
          state_next = SEARCH;
        end else begin
          state_next = LOCKED;
        end
      end
      default: begin
        state_next    = SEARCH;
        meas_bad_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clkgen or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      meas_bad  <= 1'b0;
      locked    <= 1'b0;
      sync_err  <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state    <= state_next;
      meas_bad <= meas_bad_next;
      locked   <= (state_next == LOCKED);
      sync_err <= viol;
      if (viol && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  // Coordinates and colour only move on active pixels; otherwise they hold.
  always_ff @(posedge clkgen or posedge rst) begin
    if (rst) begin
      pix_valid <= 1'b0;
      out_x     <= 11'd0;
      out_y     <= 10'd0;
      out_r     <= 4'd0;
      out_g     <= 4'd0;
      out_b     <= 4'd0;
    end else begin
      pix_valid <= active;
      if (active) begin
        out_x <= h_cnt - H_LO;
        out_y <= v_cnt - V_LO;
        out_r <= r_s1;
        out_g <= g_s1;
        out_b <= b_s1;
      end
    end
  end

endmodule
